fifo_avalon_master: RTL and testbench

- Avalon-MM initiator that drives the FIFO wrapper's slave port from the host side.
- Executes length-counted commands:
  - PUSH: move N words from a local valid/ready source stream into the FIFO.
  - POP: move N words from the FIFO to a local valid/ready sink stream.
- Flow control comes from the FIFO's sideband status {full, empty}.
- Sits between the local datapath and the Avalon-attached FIFO. Used by both producer-side and consumer-side logic.

---
 rtl/fifo_avalon_master.sv | 176 +++++++++++++++++
 tb/tb_fifo_avalon_master.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_avalon_master.sv
// fifo_avalon_master: length-counted PUSH/POP Avalon-MM initiator for the FIFO slave port.
// Optional stall timeout abort is built when FIFO_MASTER_TIMEOUT_EN is defined.
module fifo_avalon_master #(
    parameter int WIDTH          = 8,
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_dir,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [WIDTH-1:0]     src_data,
    output logic                 snk_valid,
    input  logic                 snk_ready,
    output logic [WIDTH-1:0]     snk_data,
    output logic [1:0]           avalon_address,
    output logic                 avalon_write,
    output logic                 avalon_read,
    output logic [WIDTH-1:0]     avalon_writedata,
    input  logic [WIDTH-1:0]     avalon_readdata,
    input  logic [1:0]           avalon_status,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_POP_REQ,
        S_POP_WAIT,
        S_POP_HOLD,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [LEN_WIDTH-1:0] rem;
    logic [LEN_WIDTH-1:0] rem_nxt;
    logic                 full;
    logic                 empty;
    logic                 stall;
    logic                 timeout;

    assign full  = avalon_status[1];
    assign empty = avalon_status[0];

    // Waiting on FIFO flow control, as opposed to waiting on the local stream.
    assign stall = ((state == S_PUSH) && src_valid && full) ||
                   ((state == S_POP_REQ) && empty);

    always_comb begin
        state_nxt        = state;
        rem_nxt          = rem;
        cmd_ready        = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        src_ready        = 1'b0;
        snk_valid        = 1'b0;
        avalon_write     = 1'b0;
        avalon_read      = 1'b0;
        avalon_address   = 2'd0;
        avalon_writedata = '0;
        unique case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    rem_nxt = cmd_len;
                    if (cmd_len == '0) begin
                        state_nxt = S_DONE;
                    end else if (cmd_dir) begin
                        state_nxt = S_POP_REQ;
                    end else begin
                        state_nxt = S_PUSH;
                    end
                end
            end
            S_PUSH: begin
                busy             = 1'b1;
                avalon_writedata = src_data;
                if (src_valid && !full) begin
                    src_ready    = 1'b1;
                    avalon_write = 1'b1;
                    rem_nxt      = rem - 1'b1;
                    if (rem == LEN_WIDTH'(1)) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_POP_REQ: begin
                busy = 1'b1;
                if (!empty) begin
                    avalon_read    = 1'b1;
                    avalon_address = 2'd1;
                    state_nxt      = S_POP_WAIT;
                end
            end
            S_POP_WAIT: begin
                busy      = 1'b1;
                state_nxt = S_POP_HOLD;
            end
            S_POP_HOLD: begin
                busy      = 1'b1;
                snk_valid = 1'b1;
                if (snk_ready) begin
                    rem_nxt = rem - 1'b1;
                    if (rem == LEN_WIDTH'(1)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_POP_REQ;
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (timeout) begin
            state_nxt = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            rem      <= '0;
            snk_data <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            if (state == S_POP_WAIT) begin
                snk_data <= avalon_readdata;
            end
        end
    end

`ifdef FIFO_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] stall_cnt;

    assign timeout = stall && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            error     <= 1'b0;
        end else if (cmd_valid && cmd_ready) begin
            stall_cnt <= '0;
            error     <= 1'b0;
        end else if (timeout) begin
            stall_cnt <= '0;
            error     <= 1'b1;
        end else if (avalon_read || avalon_write) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign error          = 1'b0;
    assign unused_timeout = stall ^ (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_fifo_avalon_master.sv
// tb_fifo_avalon_master: random and directed PUSH/POP commands against a queue-based
// FIFO slave model; a negedge monitor scores bus writes, sink words and done pulses.
module tb_fifo_avalon_master;

    localparam int WIDTH     = 8;
    localparam int LEN_WIDTH = 8;
    localparam int DEPTH     = 8;

    typedef struct {
        int strobes;
        bit err;
    } exp_t;

    logic                 clk;
    logic                 reset;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_dir;
    logic [LEN_WIDTH-1:0] cmd_len;
    logic                 src_valid;
    logic                 src_ready;
    logic [WIDTH-1:0]     src_data;
    logic                 snk_valid;
    logic                 snk_ready;
    logic [WIDTH-1:0]     snk_data;
    logic [1:0]           avalon_address;
    logic                 avalon_write;
    logic                 avalon_read;
    logic [WIDTH-1:0]     avalon_writedata;
    logic [WIDTH-1:0]     avalon_readdata;
    logic [1:0]           avalon_status;
    logic                 busy;
    logic                 done;
    logic                 error;

    fifo_avalon_master #(
        .WIDTH(WIDTH),
        .LEN_WIDTH(LEN_WIDTH),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir),
        .cmd_len(cmd_len),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .src_data(src_data),
        .snk_valid(snk_valid),
        .snk_ready(snk_ready),
        .snk_data(snk_data),
        .avalon_address(avalon_address),
        .avalon_write(avalon_write),
        .avalon_read(avalon_read),
        .avalon_writedata(avalon_writedata),
        .avalon_readdata(avalon_readdata),
        .avalon_status(avalon_status),
        .busy(busy),
        .done(done),
        .error(error)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int wr_total = 0;
    int strobes  = 0;
    int last_ev  = 0;

    logic [WIDTH-1:0] src_q[$];
    logic [WIDTH-1:0] exp_wr_q[$];
    logic [WIDTH-1:0] exp_snk_q[$];
    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] pw[$];
    exp_t             exp_done_q[$];

    bit               pend_wr    = 0;
    bit               pend_rd    = 0;
    bit               src_fire   = 0;
    bit               force_full = 0;
    bit               src_rand   = 0;
    bit               snk_rand   = 0;
    bit               snk_hold   = 0;
    logic [WIDTH-1:0] pend_wdata = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_reset(input string name);
        logic [25:0] outs;
        outs = {cmd_ready, src_ready, snk_valid, snk_data, avalon_address,
                avalon_write, avalon_read, avalon_writedata, busy, done, error};
        chk(outs == 26'h2000000, name, outs, 26'h2000000);
    endtask

    // FIFO slave model, source stream and sink stream, updated just after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pend_wr) fifo_q.push_back(pend_wdata);
            if (pend_rd) begin
                if (fifo_q.size() > 0) avalon_readdata = fifo_q.pop_front();
                else avalon_readdata = 8'hEE;
            end
            avalon_status = {force_full || (fifo_q.size() >= DEPTH), fifo_q.size() == 0};
            if (src_fire && src_q.size() > 0) void'(src_q.pop_front());
            src_valid = (src_q.size() > 0) && (!src_rand || $urandom_range(0, 3) != 0);
            src_data  = (src_q.size() > 0) ? src_q[0] : '0;
            snk_ready = !snk_hold && (!snk_rand || $urandom_range(0, 1) == 1);
        end
    end

    exp_t             md;
    logic [WIDTH-1:0] me;

    always @(negedge clk) begin
        cyc++;
        pend_wr  = 0;
        pend_rd  = 0;
        src_fire = 0;
        if (reset) begin
            src_fire = src_valid && src_ready;
            if (avalon_write || avalon_read) begin
                chk(!(avalon_write && avalon_read), "one_strobe",
                    {avalon_write, avalon_read}, 2'b01);
                chk(busy, "strobe_busy", busy, 1);
            end
            if (avalon_status[1]) begin
                chk(!avalon_write && !src_ready, "full_gate",
                    {avalon_write, src_ready}, 0);
            end
            if (avalon_write) begin
                chk(avalon_address == 2'd0, "wr_addr", avalon_address, 0);
                chk(src_valid && src_ready, "wr_src_hs", {src_valid, src_ready}, 2'b11);
                if (exp_wr_q.size() == 0) begin
                    chk(0, "wr_unexpected", avalon_writedata, 0);
                end else begin
                    me = exp_wr_q.pop_front();
                    chk(avalon_writedata == me, "wr_data", avalon_writedata, me);
                end
                pend_wr    = 1;
                pend_wdata = avalon_writedata;
                wr_total++;
                strobes++;
                last_ev = cyc;
            end
            if (avalon_read) begin
                chk(avalon_address == 2'd1, "rd_addr", avalon_address, 1);
                chk(!snk_valid, "rd_while_hold", snk_valid, 0);
                chk(!avalon_status[0], "rd_empty", avalon_status, 0);
                pend_rd = 1;
                strobes++;
            end
            if (snk_valid) begin
                if (exp_snk_q.size() == 0) begin
                    chk(0, "snk_unexpected", snk_data, 0);
                end else begin
                    chk(snk_data == exp_snk_q[0], "snk_data", snk_data, exp_snk_q[0]);
                    if (snk_ready) begin
                        void'(exp_snk_q.pop_front());
                        last_ev = cyc;
                    end
                end
            end
            if (busy) chk(!cmd_ready, "hold_off", cmd_ready, 0);
            if (cmd_valid && cmd_ready) begin
                strobes = 0;
                last_ev = cyc;
            end
            if (done) begin
                chk(!busy, "done_busy", busy, 0);
                if (exp_done_q.size() == 0) begin
                    chk(0, "done_unexpected", done, 0);
                end else begin
                    md = exp_done_q.pop_front();
                    chk(strobes == md.strobes, "done_strobes", strobes, md.strobes);
                    chk(error == md.err, "done_error", error, md.err);
                    if (!md.err) chk(cyc - last_ev == 1, "done_latency", cyc - last_ev, 1);
                end
            end
        end
    end

    task automatic send_cmd(input bit dir, input int len);
        int n;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_len   = LEN_WIDTH'(len);
        for (n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        if (n == 1000) chk(0, "cmd_accept", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic start_cmd(input bit dir, input int len);
        exp_t             d;
        logic [WIDTH-1:0] w;
        for (int i = 0; i < len; i++) begin
            if (dir) begin
                exp_snk_q.push_back(fifo_q[i]);
            end else begin
                w = (pw.size() > 0) ? pw.pop_front() : WIDTH'($urandom);
                src_q.push_back(w);
                exp_wr_q.push_back(w);
            end
        end
        d.strobes = len;
        d.err     = 0;
        exp_done_q.push_back(d);
        send_cmd(dir, len);
    endtask

    task automatic wait_done();
        int n;
        for (n = 0; n < 2000; n++) begin
            if (exp_done_q.size() == 0) break;
            @(negedge clk);
        end
        if (n == 2000) begin
            chk(0, "done_wait", exp_done_q.size(), 0);
            exp_done_q.delete();
            exp_wr_q.delete();
            exp_snk_q.delete();
            src_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int   base;
        int   n;
        int   len;
        bit   dir;
        exp_t d;
        reset           = 1'b0;
        cmd_valid       = 1'b0;
        cmd_dir         = 1'b0;
        cmd_len         = '0;
        src_valid       = 1'b0;
        src_data        = '0;
        snk_ready       = 1'b0;
        avalon_readdata = '0;
        avalon_status   = 2'b01;
        repeat (3) @(negedge clk);
        check_reset("reset_state");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        pw = '{8'h11, 8'h22, 8'h33, 8'h44};
        start_cmd(0, 4);
        wait_done();
        chk(fifo_q.size() == 4, "push4_fill", fifo_q.size(), 4);

        fifo_q = '{8'hA1, 8'hA2, 8'hA3};
        repeat (2) @(negedge clk);
        start_cmd(1, 3);
        wait_done();

        fifo_q.delete();
        repeat (2) @(negedge clk);
        base = wr_total;
        start_cmd(0, 5);
        for (n = 0; n < 100; n++) begin
            @(posedge clk);
            if (wr_total >= base + 2) break;
        end
        force_full = 1;
        repeat (10) @(posedge clk);
        force_full = 0;
        wait_done();
        chk(wr_total - base == 5, "push5_writes", wr_total - base, 5);

        fifo_q = '{8'hB1, 8'hB2, 8'hB3};
        repeat (2) @(negedge clk);
        snk_hold = 1;
        start_cmd(1, 2);
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (snk_valid) break;
        end
        chk(n < 50, "snk_valid_seen", n, 0);
        repeat (6) @(negedge clk);
        snk_hold = 0;
        wait_done();

        start_cmd(0, 0);
        wait_done();
        start_cmd(1, 0);
        wait_done();

        start_cmd(0, 2);
        start_cmd(0, 3);
        wait_done();
        chk(fifo_q.size() == 6, "queued_cmds_fill", fifo_q.size(), 6);

        fifo_q.delete();
        repeat (2) @(negedge clk);
        base = wr_total;
        pw = '{8'h51, 8'h52, 8'h53, 8'h54};
        start_cmd(0, 4);
        for (n = 0; n < 100; n++) begin
            @(posedge clk);
            if (wr_total >= base + 2) break;
        end
        #3;
        reset = 1'b0;
        #1;
        check_reset("reset_mid_push");
        src_q.delete();
        exp_wr_q.delete();
        exp_done_q.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        pw = '{8'h61, 8'h62};
        start_cmd(0, 2);
        wait_done();
        chk(fifo_q.size() == 4, "after_reset_fill", fifo_q.size(), 4);

        src_rand = 1;
        snk_rand = 1;
        for (int t = 0; t < 40; t++) begin
            dir = 1'($urandom_range(0, 1));
            if (dir && fifo_q.size() == 0) dir = 0;
            if (!dir && fifo_q.size() == DEPTH) dir = 1;
            if (dir) len = $urandom_range(0, fifo_q.size());
            else len = $urandom_range(0, DEPTH - fifo_q.size());
            start_cmd(dir, len);
            wait_done();
        end
        src_rand = 0;
        snk_rand = 0;

        fifo_q.delete();
        repeat (2) @(negedge clk);
`ifdef FIFO_MASTER_TIMEOUT_EN
        d.strobes = 0;
        d.err     = 1;
        exp_done_q.push_back(d);
        send_cmd(1, 2);
        wait_done();
        chk(error == 1'b1, "error_sticky", error, 1);
`else
        send_cmd(1, 2);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk(busy && !error, "no_timeout", {busy, error}, 2'b10);
        end
        d.strobes = 2;
        d.err     = 0;
        exp_done_q.push_back(d);
        exp_snk_q.push_back(8'hC1);
        exp_snk_q.push_back(8'hC2);
        fifo_q.push_back(8'hC1);
        fifo_q.push_back(8'hC2);
        wait_done();
`endif

        repeat (3) @(negedge clk);
        chk(exp_wr_q.size() == 0 && exp_snk_q.size() == 0 && exp_done_q.size() == 0,
            "queues_drained", exp_wr_q.size() + exp_snk_q.size() + exp_done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
